ram_stream_reader: RTL

Single-clock read sequencer for the read port of the team's dual-clock `RAM` block. On a start command it walks a contiguous address range, issuing one `rd_en` pulse per word and waiting for `rd_dv`. Each returned word goes onto a valid/ready output stream with a last-word flag. It is the initiator on the RAM's read side, sitting in the RAM's read-clock domain between the memory and downstream consumers.

---
 rtl/ram_stream_reader_if.sv | 32 +++
 rtl/ram_stream_reader.sv | 101 ++++++++++
 2 files changed

// File: rtl/ram_stream_reader_if.sv
// ram_stream_reader_if: command, RAM read-port and output-stream bundle for ram_stream_reader
//   command : i_start, i_base_addr, i_len -> o_busy, o_done, o_timeout
//   ram read: o_rd_en, o_rd_addr -> i_rd_data, i_rd_dv
//   stream  : o_data, o_dv, o_last -> i_ready
interface ram_stream_reader_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
) ();
  localparam int AW = $clog2(DEPTH);
  logic             i_start;
  logic [AW-1:0]    i_base_addr;
  logic [AW:0]      i_len;
  logic             o_busy;
  logic             o_done;
  logic             o_timeout;
  logic             o_rd_en;
  logic [AW-1:0]    o_rd_addr;
  logic [WIDTH-1:0] i_rd_data;
  logic             i_rd_dv;
  logic [WIDTH-1:0] o_data;
  logic             o_dv;
  logic             i_ready;
  logic             o_last;
  modport master (
    input  i_start, i_base_addr, i_len, i_rd_data, i_rd_dv, i_ready,
    output o_busy, o_done, o_timeout, o_rd_en, o_rd_addr, o_data, o_dv, o_last
  );
  modport slave (
    output i_start, i_base_addr, i_len, i_rd_data, i_rd_dv, i_ready,
    input  o_busy, o_done, o_timeout, o_rd_en, o_rd_addr, o_data, o_dv, o_last
  );
endinterface

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: walks an address range on a RAM read port and streams each word out
//   i_clk/i_rst_n : RAM read clock, async active-low reset
//   bus (master)  : start command and status, RAM read request/response, valid/ready output stream
module ram_stream_reader #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 256,
  parameter int TIMEOUT = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  ram_stream_reader_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OUT, DONE} state_t;
  state_t           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [AW:0]      rem_q, rem_d;
  logic [CW-1:0]    wait_q, wait_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
  logic rd_en_q, rd_en_d, dv_q, dv_d, last_q, last_d;
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    wait_d    = wait_q;
    data_d    = data_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: if (bus.i_start) begin
        addr_d    = bus.i_base_addr;
        rem_d     = bus.i_len > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : bus.i_len;
        timeout_d = 1'b0;
        state_d   = bus.i_len == '0 ? DONE : ISSUE;
      end
      ISSUE: begin
        wait_d  = '0;
        state_d = WAIT;
      end
      WAIT: if (bus.i_rd_dv) begin
        data_d  = bus.i_rd_data;
        state_d = OUT;
      end else begin
        wait_d = wait_q + CW'(1);
        if (wait_d == CW'(TIMEOUT)) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end
      end
      OUT: if (bus.i_ready) begin
        rem_d   = rem_q - (AW+1)'(1);
        addr_d  = addr_q + AW'(1);
        state_d = rem_q == (AW+1)'(1) ? DONE : ISSUE;
      end
      // a zero-length start spends one quiet cycle here before pulsing o_done
      DONE: state_d = done_q ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    busy_d  = state_d != IDLE;
    rd_en_d = state_d == ISSUE;
    dv_d    = state_d == OUT;
    last_d  = state_d == OUT && rem_d == (AW+1)'(1);
    done_d  = state_d == DONE && state_q != IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      wait_q    <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      rd_en_q   <= 1'b0;
      dv_q      <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      wait_q    <= wait_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      rd_en_q   <= rd_en_d;
      dv_q      <= dv_d;
      last_q    <= last_d;
    end
  end
  assign bus.o_busy    = busy_q;
  assign bus.o_done    = done_q;
  assign bus.o_timeout = timeout_q;
  assign bus.o_rd_en   = rd_en_q;
  assign bus.o_rd_addr = addr_q;
  assign bus.o_data    = data_q;
  assign bus.o_dv      = dv_q;
  assign bus.o_last    = last_q;
endmodule
